adxl345_i2c_master: RTL and testbench
=====================================

# adxl345_i2c_master

Single-clock I2C master that performs one-byte register reads and writes on the ADXL345 accelerometer. It drives the open-drain SCL/SDA pins that feed the ADXL345 I2C slave stage directly downstream. Upstream logic issues one command at a time: register address, direction and write byte. The block returns the read byte, a done pulse and an ACK-error flag.

## Interface
Parameters:
- CLK_DIV, 125: system clocks per quarter SCL period (50 MHz / (4·125) = 100 kHz); legal range 2..1023
- DEV_ADDR, 7'h53: 7-bit ADXL345 slave address (SDO/ALT pin low)

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  command strobe, sampled only in IDLE
- rw  in  1  1 = register read, 0 = register write
- reg_addr  in  8  ADXL345 register address
- wr_data  in  8  byte written when rw=0
- rd_data  out  8  byte read; updated only on a successful read
- busy  out  1  high from the accepted start until done
- done  out  1  one-cycle pulse at transaction end
- ack_error  out  1  slave NACK seen; cleared on next accepted start
- scl_oe  out  1  1 = pull SCL low
- scl_in  in  1  sampled SCL pin level
- sda_oe  out  1  1 = pull SDA low
- sda_in  in  1  sampled SDA pin level

## Operation
- Open-drain only: a line is released (high via pull-up) when its _oe is 0.
- Bit slot = 4 quarter phases of CLK_DIV clocks each. SCL is low in quarters 0–1 and high in quarters 2–3.
- SDA changes only at the start of quarter 0. SDA is sampled at the end of quarter 2.
- States: IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D, RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP.
- IDLE → START on start=1. Command fields are latched in the same cycle.
- START: SDA falls while SCL is high (quarter 2). ADDR_W then shifts {DEV_ADDR,0} MSB first.
- ACK states: SDA is released. sda_in=1 sets ack_error and jumps to STOP.
- Write path: ADDR_W → ACK_A → REG → ACK_R → WDATA → ACK_D → STOP.
- Read path: … ACK_R → RSTART → ADDR_R({DEV_ADDR,1}) → ACK_AR → RDATA → MNACK → STOP.
- MNACK: master releases SDA, which signals NACK. rd_data loads the shifted byte at the end of RDATA.
- STOP: SDA rises while SCL is high. Then done=1 for one clock, busy=0, and the FSM returns to IDLE.
- start while busy: ignored, no queuing.

## Timing
- Reset values: scl_oe=0, sda_oe=0, busy=0, done=0, ack_error=0, rd_data=8'h00, FSM=IDLE, divider=0.
- Reset mid-transaction: both lines are released on the next clock, with no STOP generated. The FSM returns to IDLE and done is not pulsed.
- busy rises the clock after start is accepted.
- Write latency: 29 slots, i.e. done at 116·CLK_DIV + 1 clocks after the start edge.
- Read latency: 39 slots (156·CLK_DIV + 1 clocks).
- NACK abort: after the ACK slot, the STOP slot follows immediately, then done.
- Divider: counts 0..CLK_DIV-1, then wraps and advances the quarter. Quarter 3 wrapping to 0 advances the bit counter (0..7, then the ACK slot).

## Configuration
- ADXL345_I2C_STRETCH_EN defined: the quarter-2 divider holds at 0 while scl_in=0 after SCL is released (clock stretching). Latency extends by the number of stretched clocks.
- ADXL345_I2C_STRETCH_EN undefined: scl_in is ignored and timing is exactly as stated above.

## Structure
- Package adxl345_pkg holds:
  - the state enum
  - DEV_ADDR default
  - write/read slot-count constants (29, 39), which the bench also uses
- Sub-module adxl345_i2c_tick: CLK_DIV divider plus 2-bit quarter counter (with the stretch hold). Outputs a quarter strobe and quarter index.
- Top level: FSM, 8-bit shift register, 3-bit bit counter, output registers.

## Test plan
- CLK_DIV=2, write reg 8'h2D data 8'h08, slave ACKs all → SDA bytes A6,2D,08 decoded. done at clock 233; ack_error=0.
- CLK_DIV=2, read reg 8'h00, slave returns 8'hE5 → bytes A6,00, Sr, A7 seen; rd_data=8'hE5; master NACKs; done at clock 313.
- Slave NACKs the address byte → ack_error=1, STOP follows immediately, done pulses, and rd_data keeps its previous value.
- start pulsed while busy → ignored; exactly one done per accepted start.
- reset asserted in the middle of the REG byte → scl_oe=sda_oe=0 next clock, busy=0, no done; a new write then completes normally.
- With ADXL345_I2C_STRETCH_EN, slave holds SCL low 10 clocks in one bit → done is 10 clocks later than nominal. Without the macro, timing is unchanged.

Source files
------------

// File: rtl/adxl345_pkg.sv
// rtl/adxl345_pkg.sv - shared states, defaults and slot counts for the ADXL345 I2C master
package adxl345_pkg;

    typedef enum logic [3:0] {
        IDLE, START, ADDR_W, ACK_A, REG, ACK_R, WDATA, ACK_D,
        RSTART, ADDR_R, ACK_AR, RDATA, MNACK, STOP
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h53;
    localparam int WR_SLOTS = 29;
    localparam int RD_SLOTS = 39;

    // Acknowledge slot that follows each master-transmitted byte
    function automatic state_t ack_state(input state_t s);
        case (s)
            ADDR_W:  return ACK_A;
            REG:     return ACK_R;
            WDATA:   return ACK_D;
            default: return ACK_AR;
        endcase
    endfunction

endpackage

// File: rtl/adxl345_i2c_tick.sv
// rtl/adxl345_i2c_tick.sv - quarter-bit timebase; ADXL345_I2C_STRETCH_EN adds SCL clock stretching
module adxl345_i2c_tick #(
    parameter int CLK_DIV = 125
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       scl_in,
    output logic       qtick,
    output logic [1:0] quarter
);

    localparam logic [9:0] DIV_LAST = 10'(CLK_DIV - 1);

    logic [9:0] div;
    logic       hold;

`ifdef ADXL345_I2C_STRETCH_EN
    // qtick marks the cycle before SCL is actually released, so it is excluded
    assign hold = (quarter == 2'd2) && !qtick && !scl_in;
`else
    logic unused_scl_in;
    assign unused_scl_in = scl_in;
    assign hold = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset || !en) begin
            div     <= '0;
            quarter <= 2'd0;
            qtick   <= 1'b0;
        end else begin
            qtick <= 1'b0;
            if (!hold) begin
                if (div == DIV_LAST) begin
                    div     <= '0;
                    quarter <= quarter + 2'd1;
                    qtick   <= 1'b1;
                end else begin
                    div <= div + 10'd1;
                end
            end
        end
    end

endmodule

// File: rtl/adxl345_i2c_master.sv
// rtl/adxl345_i2c_master.sv - one-byte ADXL345 register read/write I2C master (ADXL345_I2C_STRETCH_EN enables stretching)
module adxl345_i2c_master
    import adxl345_pkg::*;
#(
    parameter int         CLK_DIV  = 125,
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wr_data,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl_oe,
    input  logic       scl_in,
    output logic       sda_oe,
    input  logic       sda_in
);

    state_t     state;
    logic [7:0] shreg;
    logic [2:0] bitcnt;
    logic       rw_q;
    logic [7:0] reg_q;
    logic [7:0] wd_q;
    logic       qtick;
    logic [1:0] quarter;
    logic       is_ack;

    assign is_ack = (state == ACK_A) || (state == ACK_R) || (state == ACK_D) || (state == ACK_AR);

    adxl345_i2c_tick #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk     (clk),
        .reset   (reset),
        .en      (state != IDLE),
        .scl_in  (scl_in),
        .qtick   (qtick),
        .quarter (quarter)
    );

    // Outputs are updated on the cycle after each quarter wrap; quarter 0 means a slot just ended
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            scl_oe    <= 1'b0;
            sda_oe    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ack_error <= 1'b0;
            rd_data   <= 8'h00;
            shreg     <= 8'h00;
            bitcnt    <= 3'd0;
            rw_q      <= 1'b0;
            reg_q     <= 8'h00;
            wd_q      <= 8'h00;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    state     <= START;
                    busy      <= 1'b1;
                    ack_error <= 1'b0;
                    rw_q      <= rw;
                    reg_q     <= reg_addr;
                    wd_q      <= wr_data;
                    bitcnt    <= 3'd0;
                    scl_oe    <= 1'b0;
                    sda_oe    <= 1'b0;
                end
            end else if (qtick) begin
                case (quarter)
                    2'd0: begin
                        scl_oe <= 1'b1;
                        bitcnt <= 3'd0;
                        case (state)
                            START: begin
                                state  <= ADDR_W;
                                shreg  <= {DEV_ADDR, 1'b0};
                                sda_oe <= ~DEV_ADDR[6];
                            end
                            ADDR_W, REG, WDATA, ADDR_R: begin
                                if (bitcnt == 3'd7) begin
                                    state  <= ack_state(state);
                                    sda_oe <= 1'b0;
                                end else begin
                                    bitcnt <= bitcnt + 3'd1;
                                    shreg  <= {shreg[6:0], 1'b0};
                                    sda_oe <= ~shreg[6];
                                end
                            end
                            ACK_A, ACK_R, ACK_D, ACK_AR: begin
                                if (ack_error || state == ACK_D) begin
                                    state  <= STOP;
                                    sda_oe <= 1'b1;
                                end else if (state == ACK_A) begin
                                    state  <= REG;
                                    shreg  <= reg_q;
                                    sda_oe <= ~reg_q[7];
                                end else if (state == ACK_R && rw_q) begin
                                    state  <= RSTART;
                                    sda_oe <= 1'b0;
                                end else if (state == ACK_R) begin
                                    state  <= WDATA;
                                    shreg  <= wd_q;
                                    sda_oe <= ~wd_q[7];
                                end else begin
                                    state  <= RDATA;
                                    sda_oe <= 1'b0;
                                end
                            end
                            RSTART: begin
                                state  <= ADDR_R;
                                shreg  <= {DEV_ADDR, 1'b1};
                                sda_oe <= ~DEV_ADDR[6];
                            end
                            RDATA: begin
                                sda_oe <= 1'b0;
                                if (bitcnt == 3'd7) begin
                                    state   <= MNACK;
                                    rd_data <= shreg;
                                end else begin
                                    bitcnt <= bitcnt + 3'd1;
                                end
                            end
                            MNACK: begin
                                state  <= STOP;
                                sda_oe <= 1'b1;
                            end
                            default: begin
                                state  <= IDLE;
                                busy   <= 1'b0;
                                done   <= (state == STOP);
                                scl_oe <= 1'b0;
                                sda_oe <= 1'b0;
                            end
                        endcase
                    end
                    2'd1: begin
                        // Repeated start needs SCL high before SDA falls in quarter 2
                        if (state == RSTART) scl_oe <= 1'b0;
                    end
                    2'd2: begin
                        scl_oe <= 1'b0;
                        if (state == START || state == RSTART) sda_oe <= 1'b1;
                    end
                    default: begin
                        if (state == STOP) sda_oe <= 1'b0;
                        if (is_ack && sda_in) ack_error <= 1'b1;
                        if (state == RDATA) shreg <= {shreg[6:0], sda_in};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adxl345_i2c_master.sv
// tb/tb_adxl345_i2c_master.sv - directed bench with a bit-level ADXL345 slave model
module tb_adxl345_i2c_master;
    import adxl345_pkg::*;

    localparam int CLK_DIV = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wr_data = 8'h00;
    logic [7:0] rd_data;
    logic       busy, done, ack_error, scl_oe, sda_oe;
    logic       scl_in, sda_in;
    logic       stretch_hold = 1'b0;
    logic       slave_sda_low = 1'b0;

    int n_checks = 0;
    int n_pass = 0;

    assign scl_in = !scl_oe && !stretch_hold;
    assign sda_in = !sda_oe && !slave_sda_low;

    always #5 clk = ~clk;

    adxl345_i2c_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h53)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .rw        (rw),
        .reg_addr  (reg_addr),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .ack_error (ack_error),
        .scl_oe    (scl_oe),
        .scl_in    (scl_in),
        .sda_oe    (sda_oe),
        .sda_in    (sda_in)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Slave model: decodes bus (256 = start/Sr, 257 = stop), ACKs, returns tx_byte on reads
    int         log_q[$];
    int         nack_byte = -1;
    int         byte_no = 0;
    int         bitc = 0;
    logic [7:0] rx = 8'h00;
    logic [7:0] tx_sh = 8'h00;
    logic [7:0] tx_byte = 8'hE5;
    logic       ack_slot = 1'b0, tx_mode = 1'b0, pending_tx = 1'b0, addr_next = 1'b0;
    logic       m_ack = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, c_scl, c_sda;

    always @(negedge clk) begin
        c_scl = !scl_oe;
        c_sda = sda_in;
        if (c_scl && p_scl && p_sda && !c_sda) begin
            log_q.push_back(256);
            bitc = 0; ack_slot = 0; tx_mode = 0; pending_tx = 0;
            addr_next = 1; byte_no = 0; slave_sda_low = 0;
        end else if (c_scl && p_scl && !p_sda && c_sda) begin
            log_q.push_back(257);
            bitc = 0; ack_slot = 0; tx_mode = 0; slave_sda_low = 0;
        end else if (c_scl && !p_scl) begin
            if (!ack_slot) begin
                rx = {rx[6:0], c_sda};
                bitc++;
            end else if (tx_mode) begin
                m_ack = c_sda;
            end
        end else if (!c_scl && p_scl) begin
            if (ack_slot) begin
                ack_slot = 0; bitc = 0; slave_sda_low = 0;
                if (tx_mode && m_ack) tx_mode = 0;
                if (pending_tx) begin
                    tx_mode = 1; pending_tx = 0; tx_sh = tx_byte;
                end
                if (tx_mode) begin
                    slave_sda_low = !tx_sh[7];
                    tx_sh = {tx_sh[6:0], 1'b0};
                end
            end else if (bitc == 8) begin
                ack_slot = 1;
                if (tx_mode) begin
                    slave_sda_low = 0;
                end else begin
                    log_q.push_back(int'(rx));
                    slave_sda_low = (byte_no != nack_byte);
                    if (addr_next && rx[0] && slave_sda_low) pending_tx = 1;
                    addr_next = 0;
                    byte_no++;
                end
            end else if (tx_mode && bitc > 0) begin
                slave_sda_low = !tx_sh[7];
                tx_sh = {tx_sh[6:0], 1'b0};
            end
        end
        p_scl = c_scl;
        p_sda = c_sda;
    end

    task automatic check_log(input string tag, input int exp[$]);
        check({tag, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size(); i++)
            if (i < log_q.size()) check($sformatf("%s_%0d", tag, i), 32'(log_q[i]), 32'(exp[i]));
    endtask

    // Issues one command; lat = clocks from the start edge to done, nd = done cycles seen
    task automatic run_cmd(input logic r, input logic [7:0] a, input logic [7:0] d,
                           input int mid_start, output int lat, output int nd);
        @(posedge clk);
        #1 rw = r; reg_addr = a; wr_data = d; start = 1'b1;
        log_q.delete();
        @(posedge clk);
        #1 start = 1'b0;
        check("busy_rise", 32'(busy), 32'd1);
        lat = 0;
        nd = 0;
        for (int i = 1; i <= 3000; i++) begin
            @(posedge clk);
            #1;
            if (i == mid_start) begin
                start = 1'b1; rw = !r; reg_addr = 8'h55; wr_data = 8'hAA;
            end else begin
                start = 1'b0;
            end
            if (done) begin
                nd++;
                if (lat == 0) lat = i;
            end
            if (lat != 0 && i >= lat + 20) break;
        end
        start = 1'b0;
    endtask

    int lat, nd, wr_lat, rd_lat, stretch_lat;
    int exp_q[$];

    initial begin
        wr_lat = WR_SLOTS * 4 * CLK_DIV + 1;
        rd_lat = RD_SLOTS * 4 * CLK_DIV + 1;
`ifdef ADXL345_I2C_STRETCH_EN
        stretch_lat = wr_lat + 10;
`else
        stretch_lat = wr_lat;
`endif
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_scl_oe", 32'(scl_oe), 32'd0);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ack_error", 32'(ack_error), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);

        run_cmd(1'b0, 8'h2D, 8'h08, 0, lat, nd);
        check("wr_latency", 32'(lat), 32'd233);
        check("wr_done_cnt", 32'(nd), 32'd1);
        check("wr_ack_error", 32'(ack_error), 32'd0);
        check("wr_busy_end", 32'(busy), 32'd0);
        exp_q = {256, 8'hA6, 8'h2D, 8'h08, 257};
        check_log("wr_bus", exp_q);

        run_cmd(1'b1, 8'h00, 8'h00, 0, lat, nd);
        check("rd_latency", 32'(lat), 32'(rd_lat));
        check("rd_latency_abs", 32'(lat), 32'd313);
        check("rd_done_cnt", 32'(nd), 32'd1);
        check("rd_data", 32'(rd_data), 32'hE5);
        check("rd_ack_error", 32'(ack_error), 32'd0);
        check("rd_master_nack", 32'(m_ack), 32'd1);
        exp_q = {256, 8'hA6, 8'h00, 256, 8'hA7, 257};
        check_log("rd_bus", exp_q);

        nack_byte = 0;
        run_cmd(1'b0, 8'h31, 8'h0B, 0, lat, nd);
        nack_byte = -1;
        check("nack_latency", 32'(lat), 32'd89);
        check("nack_done_cnt", 32'(nd), 32'd1);
        check("nack_ack_error", 32'(ack_error), 32'd1);
        check("nack_rd_keep", 32'(rd_data), 32'hE5);
        exp_q = {256, 8'hA6, 257};
        check_log("nack_bus", exp_q);

        run_cmd(1'b0, 8'h2C, 8'h0A, 50, lat, nd);
        check("ign_latency", 32'(lat), 32'(wr_lat));
        check("ign_done_cnt", 32'(nd), 32'd1);
        check("ign_ack_clear", 32'(ack_error), 32'd0);
        exp_q = {256, 8'hA6, 8'h2C, 8'h0A, 257};
        check_log("ign_bus", exp_q);

        @(posedge clk);
        #1 rw = 1'b0; reg_addr = 8'h2D; wr_data = 8'h08; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 check("mid_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1 check("mid_scl_oe", 32'(scl_oe), 32'd0);
        check("mid_sda_oe", 32'(sda_oe), 32'd0);
        check("mid_busy_clr", 32'(busy), 32'd0);
        nd = 32'(done);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1 if (done) nd++;
        end
        check("mid_no_done", 32'(nd), 32'd0);

        run_cmd(1'b0, 8'h2D, 8'h08, 0, lat, nd);
        check("post_latency", 32'(lat), 32'(wr_lat));
        check("post_done_cnt", 32'(nd), 32'd1);
        exp_q = {256, 8'hA6, 8'h2D, 8'h08, 257};
        check_log("post_bus", exp_q);

        fork
            run_cmd(1'b0, 8'h2D, 8'h08, 0, lat, nd);
            begin : stretcher
                logic prev;
                repeat (60) @(posedge clk);
                #1 prev = scl_oe;
                for (int k = 0; k < 200; k++) begin
                    @(posedge clk);
                    #1;
                    if (prev && !scl_oe) begin
                        stretch_hold = 1'b1;
                        repeat (10) @(posedge clk);
                        #1 stretch_hold = 1'b0;
                        break;
                    end
                    prev = scl_oe;
                end
            end
        join
        check("stretch_latency", 32'(lat), 32'(stretch_lat));
        check("stretch_done_cnt", 32'(nd), 32'd1);
        check_log("stretch_bus", exp_q);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
